// File: rtl/uart_bus_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// uart_bus_arbiter : round-robin share of one UART window between two
//                    native-bus requesters, registered response, timeout.
// Revision         : 1.0
// ============================================================================
module uart_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_enable,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam logic [1:0]  c_st_idle  = 2'd0;
  localparam logic [1:0]  c_st_busy  = 2'd1;
  localparam logic [1:0]  c_st_resp  = 2'd2;
  localparam logic [1:0]  c_st_gap   = 2'd3;
  localparam logic [19:0] c_cnt_last = 20'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [19:0] r_cnt;
  logic        r_last;
  logic [1:0]  r_grant;
  logic        r_s_valid;
  logic [3:0]  r_s_wstrb;
  logic [31:0] r_s_wdata;
  logic [31:0] r_s_addr;
  logic        r_m0_ready;
  logic        r_m1_ready;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        r_err;

  logic        w_any;
  logic        w_pick1;
  logic        w_hit;
  logic        w_done;
  logic        w_abort;
  logic        w_s_valid_nxt;
  logic [1:0]  w_grant_nxt;
  logic        w_m0_ready_nxt;
  logic        w_m1_ready_nxt;
  logic [31:0] w_rdata_nxt;
  logic        w_err_nxt;

  // r_last holds the index of the previous winner; the other side wins a tie.
  assign w_any   = m0_valid | m1_valid;
  assign w_pick1 = m1_valid & (~m0_valid | ~r_last);
  assign w_hit   = (r_cnt == c_cnt_last);
  assign w_done  = (r_state == c_st_busy) & (s_ready | w_hit);
  assign w_abort = (r_state == c_st_busy) & ~s_ready & w_hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_any) w_state_nxt = c_st_busy;
      c_st_busy: if (s_ready | w_hit) w_state_nxt = c_st_resp;
      c_st_resp: w_state_nxt = c_st_gap;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_s_valid_nxt = 1'b0;
    w_grant_nxt   = r_grant;
    case (r_state)
      c_st_idle: begin
        w_s_valid_nxt = w_any;
        w_grant_nxt   = w_any ? {w_pick1, ~w_pick1} : 2'b00;
      end
      c_st_busy: w_s_valid_nxt = ~w_done;
      default:   w_grant_nxt   = 2'b00;
    endcase
    w_m0_ready_nxt = w_done & r_grant[0];
    w_m1_ready_nxt = w_done & r_grant[1];
    // A UART answer on the limit cycle still counts as success.
    w_rdata_nxt    = s_ready ? s_rdata : 32'hFFFF_FFFF;
    w_err_nxt      = w_abort ? 1'b1 : (err_clr ? 1'b0 : r_err);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_grant    <= 2'b00;
      r_s_valid  <= 1'b0;
      r_s_wstrb  <= '0;
      r_s_wdata  <= '0;
      r_s_addr   <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_err      <= 1'b0;
    end else begin
      r_s_valid  <= w_s_valid_nxt;
      r_grant    <= w_grant_nxt;
      r_m0_ready <= w_m0_ready_nxt;
      r_m1_ready <= w_m1_ready_nxt;
      r_m0_rdata <= w_m0_ready_nxt ? w_rdata_nxt : 32'd0;
      r_m1_rdata <= w_m1_ready_nxt ? w_rdata_nxt : 32'd0;
      r_err      <= w_err_nxt;
      if ((r_state == c_st_idle) && w_any) begin
        r_last    <= w_pick1;
        r_cnt     <= '0;
        r_s_wstrb <= w_pick1 ? m1_wstrb : m0_wstrb;
        r_s_wdata <= w_pick1 ? m1_wdata : m0_wdata;
        r_s_addr  <= w_pick1 ? m1_addr  : m0_addr;
      end else if ((r_state == c_st_busy) && !w_done) begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  assign s_valid     = r_s_valid;
  assign s_enable    = r_s_valid;
  assign s_wstrb     = r_s_wstrb;
  assign s_wdata     = r_s_wdata;
  assign s_addr      = r_s_addr;
  assign grant       = r_grant;
  assign m0_ready    = r_m0_ready;
  assign m1_ready    = r_m1_ready;
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_uart_bus_arbiter : scoreboard bench for uart_bus_arbiter (TIMEOUT 8).
// Revision            : 1.0
// ============================================================================
module tb_uart_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_wdata, m1_wdata, m0_addr, m1_addr;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_enable, s_ready;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata, s_addr, s_rdata;
  logic [1:0]  grant;
  logic        err_timeout, err_clr;

  uart_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_enable(s_enable), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr(s_addr), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  g;
    logic [3:0]  st;
    logic [31:0] wd;
    logic [31:0] ad;
    logic [31:0] len;
  } sexp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  sexp_t       sq[$];
  int          rdy_cnt0 = 0, rdy_cnt1 = 0;
  logic        err_at_rdy = 1'b0, err_pre_rdy = 1'b0, err_prev = 1'b0;

  // UART model: answers on the (uart_delay+1)-th cycle of s_valid unless hung.
  int          uart_delay = 0;
  logic        uart_hang = 1'b0;
  logic [31:0] uart_rdata = '0;
  int          sv_cnt = 0;
  assign s_ready = s_valid && !uart_hang && (sv_cnt == uart_delay);
  assign s_rdata = uart_rdata;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn || !s_valid || s_ready) sv_cnt <= 0;
    else sv_cnt <= sv_cnt + 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic flag(input string nm, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", nm, what);
  endtask

  task automatic spush(input logic [1:0] g, input logic [3:0] st, input logic [31:0] wd,
                       input logic [31:0] ad, input int len);
    sexp_t e;
    e.g = g; e.st = st; e.wd = wd; e.ad = ad; e.len = 32'(len);
    sq.push_back(e);
  endtask

  // Requester side: pops the expected rdata whenever a ready pulse appears.
  logic after0 = 1'b0, after1 = 1'b0;
  always @(negedge clk) begin
    if (m0_ready) begin
      rdy_cnt0++;
      err_at_rdy  = err_timeout;
      err_pre_rdy = err_prev;
      if (exp_q0.size() == 0) flag("m0 ready", "got unexpected pulse, want none");
      else chk("m0 rdata", 128'(m0_rdata), 128'(exp_q0.pop_front()));
      chk("m0 grant at ready", 128'(grant), 128'(2'b01));
      after0 = 1'b1;
    end else if (after0) begin
      after0 = 1'b0;
      chk("m0 pulse end", 128'({grant, m0_rdata}), 128'(0));
    end
    if (m1_ready) begin
      rdy_cnt1++;
      if (exp_q1.size() == 0) flag("m1 ready", "got unexpected pulse, want none");
      else chk("m1 rdata", 128'(m1_rdata), 128'(exp_q1.pop_front()));
      chk("m1 grant at ready", 128'(grant), 128'(2'b10));
      after1 = 1'b1;
    end else if (after1) begin
      after1 = 1'b0;
      chk("m1 pulse end", 128'({grant, m1_rdata}), 128'(0));
    end
    err_prev = err_timeout;
  end

  // UART side: each s_valid burst is matched against the next expected request.
  sexp_t cur = '0;
  logic [69:0] snap = '0;
  int hi_run = 0, lo_run = 100;
  logic sv_prev = 1'b0, unstable = 1'b0;
  always @(negedge clk) begin
    if (s_valid && !sv_prev) begin
      chk("s idle gap >= 3", 128'(lo_run >= 3), 128'(1));
      chk("s_enable high", 128'(s_enable), 128'(1));
      if (sq.size() == 0) flag("s request", "got unexpected request, want none");
      else begin
        cur = sq.pop_front();
        chk("s request", 128'({grant, s_wstrb, s_wdata, s_addr}),
            128'({cur.g, cur.st, cur.wd, cur.ad}));
      end
      snap = {grant, s_wstrb, s_wdata, s_addr};
      hi_run = 1; lo_run = 0; unstable = 1'b0;
    end else if (s_valid) begin
      hi_run++;
      if ({grant, s_wstrb, s_wdata, s_addr} !== snap || !s_enable) unstable = 1'b1;
    end else if (sv_prev) begin
      chk("s_valid width", 128'(hi_run), 128'(cur.len));
      chk("s stable", 128'({unstable, s_enable}), 128'(0));
      lo_run = 1;
    end else begin
      lo_run++;
    end
    sv_prev = s_valid;
  end

  task automatic set_req(input bit m, input logic v, input logic [3:0] st,
                         input logic [31:0] wd, input logic [31:0] ad);
    if (!m) begin m0_valid = v; m0_wstrb = st; m0_wdata = wd; m0_addr = ad; end
    else    begin m1_valid = v; m1_wstrb = st; m1_wdata = wd; m1_addr = ad; end
  endtask

  // Issues n back-to-back transactions with valid held throughout.
  task automatic do_req(input bit m, input logic [3:0] st, input logic [31:0] wd,
                        input logic [31:0] ad, input logic [31:0] rd, input int n,
                        input bit abandon, output int lat);
    int  t0;
    bit  got;
    @(posedge clk); #1;
    set_req(m, 1'b1, st, wd, ad);
    t0  = cyc;
    lat = -1;
    for (int k = 0; k < n; k++) begin
      if (!m) exp_q0.push_back(rd); else exp_q1.push_back(rd);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (abandon && i == 2) set_req(m, 1'b0, st, wd, ad);
        got = m ? m1_ready : m0_ready;
      end
      if (!got) begin
        flag(m ? "m1 ready wait" : "m0 ready wait", "got no pulse in 100 cycles, want one");
        break;
      end
      if (k == 0) lat = cyc - t0;
    end
    @(posedge clk); #1;
    set_req(m, 1'b0, st, wd, ad);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    chk("queues drained", 128'(exp_q0.size() + exp_q1.size() + sq.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int l0, l1;
    resetn = 1'b0; err_clr = 1'b0;
    set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset s side", 128'({s_valid, s_enable, s_wstrb, s_wdata, s_addr, grant}), 128'(0));
    chk("reset m side", 128'({m0_ready, m1_ready, m0_rdata, m1_rdata, err_timeout}), 128'(0));

    // Contention: m0 wins first, then strict alternation.
    uart_delay = 0; uart_rdata = 32'h0000_0077;
    spush(2'b01, 4'hF, 32'h41, 32'h0, 1);
    spush(2'b10, 4'hF, 32'h42, 32'h0, 1);
    spush(2'b01, 4'hF, 32'h41, 32'h0, 1);
    spush(2'b10, 4'hF, 32'h42, 32'h0, 1);
    rdy_cnt0 = 0; rdy_cnt1 = 0;
    fork
      do_req(1'b0, 4'hF, 32'h41, 32'h0, 32'h77, 2, 1'b0, l0);
      do_req(1'b1, 4'hF, 32'h42, 32'h0, 32'h77, 2, 1'b0, l1);
    join
    drain();
    chk("contention ready counts", 128'({rdy_cnt0, rdy_cnt1}), 128'({32'd2, 32'd2}));

    // Single read, one-cycle UART latency.
    uart_delay = 1; uart_rdata = 32'h60;
    spush(2'b01, 4'h0, 32'h0, 32'h14, 2);
    do_req(1'b0, 4'h0, 32'h0, 32'h14, 32'h60, 1, 1'b0, l0);
    chk("single read latency", 128'(l0), 128'(3));
    drain();

    // Slow FIFO read on m1 with an m0 write queued behind it.
    uart_delay = 3; uart_rdata = 32'h55;
    spush(2'b10, 4'h0, 32'h0, 32'h0, 4);
    spush(2'b01, 4'hF, 32'hAB, 32'h4, 4);
    fork
      do_req(1'b1, 4'h0, 32'h0, 32'h0, 32'h55, 1, 1'b0, l1);
      begin
        @(posedge clk);
        do_req(1'b0, 4'hF, 32'hAB, 32'h4, 32'h55, 1, 1'b0, l0);
      end
    join
    chk("fifo read latency", 128'(l1), 128'(5));
    drain();

    // m1 abandons its request mid-transaction.
    uart_delay = 2; uart_rdata = 32'h99;
    rdy_cnt1 = 0;
    spush(2'b10, 4'h0, 32'h0, 32'h8, 3);
    do_req(1'b1, 4'h0, 32'h0, 32'h8, 32'h99, 1, 1'b1, l1);
    chk("abandon latency", 128'(l1), 128'(4));
    drain();
    chk("abandon ready count", 128'(rdy_cnt1), 128'(1));

    // Answer on the very last allowed cycle is a success.
    uart_delay = 7; uart_rdata = 32'h1234_5678;
    spush(2'b01, 4'h0, 32'h0, 32'h10, 8);
    do_req(1'b0, 4'h0, 32'h0, 32'h10, 32'h1234_5678, 1, 1'b0, l0);
    chk("limit-cycle ready latency", 128'(l0), 128'(9));
    chk("limit-cycle no error", 128'({err_at_rdy, err_timeout}), 128'(0));
    drain();

    // Timeout with a hung UART.
    uart_hang = 1'b1;
    spush(2'b01, 4'h0, 32'h0, 32'h18, 8);
    do_req(1'b0, 4'h0, 32'h0, 32'h18, 32'hFFFF_FFFF, 1, 1'b0, l0);
    chk("timeout latency", 128'(l0), 128'(9));
    chk("err rises with ready", 128'({err_pre_rdy, err_at_rdy}), 128'(2'b01));
    repeat (3) @(negedge clk);
    chk("err held", 128'(err_timeout), 128'(1));
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err cleared", 128'(err_timeout), 128'(0));
    drain();

    // Set wins over a simultaneous clear.
    err_clr = 1'b1;
    spush(2'b01, 4'h0, 32'h0, 32'h1C, 8);
    do_req(1'b0, 4'h0, 32'h0, 32'h1C, 32'hFFFF_FFFF, 1, 1'b0, l0);
    chk("set beats clear", 128'({err_pre_rdy, err_at_rdy}), 128'(2'b01));
    err_clr = 1'b0;
    @(negedge clk);
    chk("clear after set", 128'(err_timeout), 128'(0));
    drain();

    // Reset during BUSY, then a contended request goes to m0.
    spush(2'b01, 4'hF, 32'hDEAD, 32'h20, 3);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'hF, 32'hDEAD, 32'h20);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("mid-busy reset", 128'({s_valid, grant, m0_ready, m1_ready, s_wstrb, s_wdata, s_addr}),
        128'(0));
    uart_hang = 1'b0; uart_delay = 0; uart_rdata = 32'hC0DE;
    repeat (3) @(negedge clk);
    spush(2'b01, 4'hF, 32'hC0, 32'h8, 1);
    spush(2'b10, 4'hF, 32'hC1, 32'hC, 1);
    fork
      do_req(1'b0, 4'hF, 32'hC0, 32'h8, 32'hC0DE, 1, 1'b0, l0);
      do_req(1'b1, 4'hF, 32'hC1, 32'hC, 32'hC0DE, 1, 1'b0, l1);
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
